// File: rtl/cn_ff_bank.sv
// Bank of WIDTH flip-flop channels sharing one mode: CN, D, T or JK, with parallel load and change tracking.
// Latency: q, changed and chg_cnt update one clock after inputs are sampled; qbar is combinational from q.
// Backpressure: none; inputs are sampled on every rising edge and the block is never stalled.
module cn_ff_bank #(
   parameter int unsigned          WIDTH     = 4,
   parameter int unsigned          CNT_W     = 8,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] changed,
   output logic [CNT_W-1:0] chg_cnt
);

   typedef enum logic [1:0] {
      MODE_CN = 2'b00,
      MODE_D  = 2'b01,
      MODE_T  = 2'b10,
      MODE_JK = 2'b11
   } mode_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] func_next;
   logic [WIDTH-1:0] q_next;
   logic             q_diff;

   // Per-channel next state for the selected flip-flop behaviour.
   // CN: with b low the bit holds; with b high a set bit clears and a clear bit takes a.
   always_comb begin
      func_next = q;
      case (mode_t'(mode))
         MODE_CN: func_next = (q & ~b) | (~q & a & b);
         MODE_D:  func_next = a;
         MODE_T:  func_next = q ^ a;
         MODE_JK: func_next = (a & ~q) | (~b & q);
         default: func_next = q;
      endcase
   end

   // Load wins over enable; with neither asserted the bank holds.
   always_comb begin
      q_next = q;
      if (load) begin
         q_next = load_val;
      end else if (en) begin
         q_next = func_next;
      end
      q_diff = (q_next != q);
   end

   assign qbar = ~q;

   // Channel state and the mask of bits that flipped on this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q       <= RESET_VAL;
         changed <= '0;
      end else begin
         q       <= q_next;
         changed <= q_next ^ q;
      end
   end

   // Saturating count of edges on which q changed; clear overrides a same-edge increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chg_cnt <= '0;
      end else if (clr_cnt) begin
         chg_cnt <= '0;
      end else if (q_diff && (chg_cnt != CNT_MAX)) begin
         chg_cnt <= chg_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cn_ff_bank.sv
// Directed and random checks of cn_ff_bank (default build plus a 2-bit counter build).
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: not applicable.
module tb_cn_ff_bank;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] mode;
   logic [3:0] a, b, load_val;
   logic       en, load, clr_cnt;
   logic [3:0] q, qbar, changed;
   logic [7:0] chg_cnt;
   logic [3:0] q2, qbar2, changed2;
   logic [1:0] chg_cnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cn_ff_bank #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode), .a(a), .b(b), .en(en),
      .load(load), .load_val(load_val), .clr_cnt(clr_cnt),
      .q(q), .qbar(qbar), .changed(changed), .chg_cnt(chg_cnt)
   );

   cn_ff_bank #(.WIDTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .mode(mode), .a(a), .b(b), .en(en),
      .load(load), .load_val(load_val), .clr_cnt(clr_cnt),
      .q(q2), .qbar(qbar2), .changed(changed2), .chg_cnt(chg_cnt2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bit-by-bit reference written from the truth tables.
   function automatic logic [3:0] ref_next(input logic [3:0] cq, input logic [1:0] m,
                                           input logic [3:0] ia, input logic [3:0] ib,
                                           input logic ien, input logic ild,
                                           input logic [3:0] ilv);
      logic [3:0] n;
      n = cq;
      if (ild) return ilv;
      if (!ien) return cq;
      for (int i = 0; i < 4; i++) begin
         case (m)
            2'b00: n[i] = !ib[i] ? cq[i] : (!cq[i] ? ia[i] : 1'b0);
            2'b01: n[i] = ia[i];
            2'b10: n[i] = ia[i] ? ~cq[i] : cq[i];
            default: begin
               case ({ia[i], ib[i]})
                  2'b00: n[i] = cq[i];
                  2'b01: n[i] = 1'b0;
                  2'b10: n[i] = 1'b1;
                  default: n[i] = ~cq[i];
               endcase
            end
         endcase
      end
      return n;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; mode = 2'b00; a = '0; b = '0; en = 1'b0; load = 1'b0;
      load_val = '0; clr_cnt = 1'b0;
      step();
      total++; if (q !== 4'b0000) begin bad++; $display("FAIL reset_q got=%b exp=0000", q); end
      total++; if (qbar !== 4'b1111) begin bad++; $display("FAIL reset_qbar got=%b exp=1111", qbar); end
      total++; if (changed !== 4'b0000) begin bad++; $display("FAIL reset_changed got=%b exp=0000", changed); end
      total++; if (chg_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", chg_cnt); end
      #2 reset_n = 1'b1;
   endtask

   task automatic test_cn();
      mode = 2'b00; a = 4'b1111; b = 4'b1111; en = 1'b1;
      step();
      total++; if (q !== 4'b1111) begin bad++; $display("FAIL cn_set_q got=%b exp=1111", q); end
      total++; if (changed !== 4'b1111) begin bad++; $display("FAIL cn_set_changed got=%b exp=1111", changed); end
      total++; if (chg_cnt !== 8'd1) begin bad++; $display("FAIL cn_set_cnt got=%0d exp=1", chg_cnt); end
      step();
      total++; if (q !== 4'b0000) begin bad++; $display("FAIL cn_clear_q got=%b exp=0000", q); end
      total++; if (chg_cnt !== 8'd2) begin bad++; $display("FAIL cn_clear_cnt got=%0d exp=2", chg_cnt); end
      b = 4'b0000;
      step();
      total++; if (q !== 4'b0000) begin bad++; $display("FAIL cn_hold_q got=%b exp=0000", q); end
      total++; if (changed !== 4'b0000) begin bad++; $display("FAIL cn_hold_changed got=%b exp=0000", changed); end
      total++; if (chg_cnt !== 8'd2) begin bad++; $display("FAIL cn_hold_cnt got=%0d exp=2", chg_cnt); end
   endtask

   task automatic test_modes();
      logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
      logic [3:0] exps  [4] = '{4'b0011, 4'b0110, 4'b0011, 4'b0011};
      for (int k = 0; k < 4; k++) begin
         load = 1'b1; load_val = 4'b0101; en = 1'b0;
         step();
         load = 1'b0; en = 1'b1; mode = modes[k]; a = 4'b0011; b = 4'b0110;
         step();
         total++;
         if (q !== exps[k]) begin
            bad++; $display("FAIL mode_sweep mode=%b got=%b exp=%b", modes[k], q, exps[k]);
         end
         total++;
         if (qbar !== ~exps[k]) begin
            bad++; $display("FAIL mode_sweep_qbar mode=%b got=%b exp=%b", modes[k], qbar, ~exps[k]);
         end
      end
   endtask

   task automatic test_load();
      logic [7:0] cnt_before;
      mode = 2'b10; a = 4'b1111; en = 1'b0; load = 1'b1; load_val = 4'b1010;
      step();
      total++; if (q !== 4'b1010) begin bad++; $display("FAIL load_q got=%b exp=1010", q); end
      cnt_before = chg_cnt;
      step();
      total++; if (changed !== 4'b0000) begin bad++; $display("FAIL load_same_changed got=%b exp=0000", changed); end
      total++; if (chg_cnt !== cnt_before) begin bad++; $display("FAIL load_same_cnt got=%0d exp=%0d", chg_cnt, cnt_before); end
      load = 1'b0; en = 1'b0;
      step();
      total++; if (q !== 4'b1010) begin bad++; $display("FAIL en_low_hold got=%b exp=1010", q); end
      load = 1'b1; en = 1'b1; load_val = 4'b0110;
      step();
      total++; if (q !== 4'b0110) begin bad++; $display("FAIL load_over_en got=%b exp=0110", q); end
      total++; if (changed !== 4'b1100) begin bad++; $display("FAIL load_changed got=%b exp=1100", changed); end
      load = 1'b0;
   endtask

   task automatic test_saturate();
      logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      en = 1'b0; load = 1'b0; clr_cnt = 1'b1;
      step();
      total++; if (chg_cnt2 !== 2'd0) begin bad++; $display("FAIL sat_clear got=%0d exp=0", chg_cnt2); end
      clr_cnt = 1'b0; mode = 2'b10; a = 4'b1111; en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         total++;
         if (chg_cnt2 !== exp2[k]) begin
            bad++; $display("FAIL sat_cnt edge=%0d got=%0d exp=%0d", k + 1, chg_cnt2, exp2[k]);
         end
      end
      total++; if (chg_cnt !== 8'd5) begin bad++; $display("FAIL wide_cnt got=%0d exp=5", chg_cnt); end
      clr_cnt = 1'b1;
      step();
      total++; if (chg_cnt2 !== 2'd0) begin bad++; $display("FAIL clr_over_inc got=%0d exp=0", chg_cnt2); end
      total++; if (changed2 !== 4'b1111) begin bad++; $display("FAIL clr_changed got=%b exp=1111", changed2); end
      clr_cnt = 1'b0;
   endtask

   task automatic test_reset_mid();
      load = 1'b1; load_val = 4'b1111; en = 1'b1; mode = 2'b10; a = 4'b1111;
      step();
      total++; if (q !== 4'b1111) begin bad++; $display("FAIL pre_reset_q got=%b exp=1111", q); end
      load = 1'b0;
      reset_n = 1'b0;
      #2;
      total++; if (q !== 4'b0000) begin bad++; $display("FAIL async_q got=%b exp=0000", q); end
      total++; if (qbar !== 4'b1111) begin bad++; $display("FAIL async_qbar got=%b exp=1111", qbar); end
      total++; if (chg_cnt !== 8'd0) begin bad++; $display("FAIL async_cnt got=%0d exp=0", chg_cnt); end
      total++; if (changed !== 4'b0000) begin bad++; $display("FAIL async_changed got=%b exp=0000", changed); end
      #2 reset_n = 1'b1;
      mode = 2'b01; a = 4'b0110;
      step();
      total++; if (q !== 4'b0110) begin bad++; $display("FAIL post_reset_q got=%b exp=0110", q); end
      total++; if (chg_cnt !== 8'd1) begin bad++; $display("FAIL post_reset_cnt got=%0d exp=1", chg_cnt); end
   endtask

   task automatic test_random();
      logic [3:0] mq, mchg, nq;
      logic [7:0] mcnt;
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      mq = 4'b0000; mchg = 4'b0000; mcnt = 8'd0;
      for (int c = 0; c < 10000; c++) begin
         mode     = 2'($urandom_range(0, 3));
         a        = 4'($urandom);
         b        = 4'($urandom);
         en       = ($urandom_range(0, 3) != 0);
         load     = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom);
         clr_cnt  = ($urandom_range(0, 63) == 0);
         nq = ref_next(mq, mode, a, b, en, load, load_val);
         mchg = nq ^ mq;
         if (clr_cnt) mcnt = 8'd0;
         else if (nq != mq && mcnt != 8'd255) mcnt = mcnt + 8'd1;
         mq = nq;
         step();
         total++; if (q !== mq) begin bad++; $display("FAIL rand_q cyc=%0d got=%b exp=%b", c, q, mq); end
         total++; if (qbar !== ~mq) begin bad++; $display("FAIL rand_qbar cyc=%0d got=%b exp=%b", c, qbar, ~mq); end
         total++; if (changed !== mchg) begin bad++; $display("FAIL rand_changed cyc=%0d got=%b exp=%b", c, changed, mchg); end
         total++; if (chg_cnt !== mcnt) begin bad++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, chg_cnt, mcnt); end
      end
   endtask

   initial begin
      test_reset();
      test_cn();
      test_modes();
      test_load();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
